// File: rtl/l5_pkg.sv
// Shared types and sizing for the layer-5 classifier stage.
package l5_pkg;

  localparam int N_IN      = 64;
  localparam int N_OUT     = 10;
  localparam int DW        = 18;
  localparam int WW        = 9;
  localparam int AW        = 36;
  // The ROM row just past the last weight row holds the biases.
  localparam int BIAS_ADDR = N_IN;
  localparam int IDX_W     = $clog2(N_IN);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MAC    = 3'd1,
    DRAIN  = 3'd2,
    ARGMAX = 3'd3,
    OUT    = 3'd4
  } state_t;

endpackage

// File: rtl/l5_mac.sv
// N_OUT parallel signed multiply-accumulate lanes sharing one activation.
// Each lane adds either activation*weight or the shifted, sign-extended bias.
module l5_mac
  import l5_pkg::*;
#(
  parameter int BIAS_SHIFT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 bias_sel,
  input  logic signed [DW-1:0] activation,
  input  logic [N_OUT*WW-1:0]  weight_row,
  output logic signed [AW-1:0] acc [N_OUT]
);

  logic signed [WW-1:0]    w_s    [N_OUT];
  logic signed [DW+WW-1:0] prod_s [N_OUT];
  logic signed [AW-1:0]    bias_s [N_OUT];
  logic signed [AW-1:0]    term_s [N_OUT];
  logic signed [AW-1:0]    acc_r  [N_OUT];

  // Per-lane addend: 27-bit product or bias, both sign-extended to AW.
  always_comb begin
    for (int j = 0; j < N_OUT; j++) begin
      w_s[j]    = $signed(weight_row[j*WW +: WW]);
      prod_s[j] = activation * w_s[j];
      bias_s[j] = AW'(w_s[j]) <<< BIAS_SHIFT;
      if (bias_sel) begin
        term_s[j] = bias_s[j];
      end else begin
        term_s[j] = AW'(prod_s[j]);
      end
    end
  end

  // Accumulators: cleared at frame acceptance, stepped on each valid ROM row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < N_OUT; j++) acc_r[j] <= '0;
    end else if (clr) begin
      for (int j = 0; j < N_OUT; j++) acc_r[j] <= '0;
    end else if (en) begin
      for (int j = 0; j < N_OUT; j++) acc_r[j] <= acc_r[j] + term_s[j];
    end else begin
      for (int j = 0; j < N_OUT; j++) acc_r[j] <= acc_r[j];
    end
  end

  assign acc = acc_r;

endmodule

// File: rtl/layer_5.sv
// Final classifier stage: captures layer-4 activations, runs 10 MAC lanes
// over a synchronous weight ROM, then a sequential argmax with a
// valid/ready result port.
module layer_5
  import l5_pkg::*;
#(
  parameter int BIAS_SHIFT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 strt,
  input  logic signed [DW-1:0] din [N_IN],
  output logic                 tx_done,
  output logic [6:0]           wt_addr,
  input  logic [N_OUT*WW-1:0]  wt_data,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           class_id,
  output logic signed [AW-1:0] score
);

  state_t               state_r, state_nx;
  logic [6:0]           cnt_r;
  logic [6:0]           idx_d_r;
  logic                 valid_d_r;
  logic [3:0]           arg_i_r;
  logic signed [DW-1:0] buf_r [N_IN];
  logic                 tx_done_r, busy_r, out_valid_r;
  logic [3:0]           class_id_r;
  logic signed [AW-1:0] score_r;
  logic                 accept_s;
  logic                 bias_sel_s;
  logic signed [DW-1:0] act_s;
  logic signed [AW-1:0] acc_s [N_OUT];

  assign accept_s = (state_r == IDLE) && strt;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state decode; strt only matters in IDLE.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: begin
        if (strt) state_nx = MAC;
        else      state_nx = IDLE;
      end
      MAC: begin
        if (cnt_r == 7'(BIAS_ADDR)) state_nx = DRAIN;
        else                        state_nx = MAC;
      end
      DRAIN:  state_nx = ARGMAX;
      ARGMAX: begin
        if (arg_i_r == 4'(N_OUT - 1)) state_nx = OUT;
        else                          state_nx = ARGMAX;
      end
      OUT: begin
        if (out_ready) state_nx = IDLE;
        else           state_nx = OUT;
      end
      default: state_nx = IDLE;
    endcase
  end

  // ROM address counter: 0..BIAS_ADDR during MAC, holds elsewhere.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= 7'd0;
    end else if (accept_s) begin
      cnt_r <= 7'd0;
    end else if ((state_r == MAC) && (cnt_r != 7'(BIAS_ADDR))) begin
      cnt_r <= cnt_r + 7'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Delayed index tracks which row the ROM is returning this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_d_r   <= 7'd0;
      valid_d_r <= 1'b0;
    end else begin
      idx_d_r   <= cnt_r;
      valid_d_r <= (state_r == MAC);
    end
  end

  // Activation capture buffer, loaded once per accepted frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_IN; i++) buf_r[i] <= '0;
    end else if (accept_s) begin
      for (int i = 0; i < N_IN; i++) buf_r[i] <= din[i];
    end else begin
      for (int i = 0; i < N_IN; i++) buf_r[i] <= buf_r[i];
    end
  end

  // Select the activation for the row in flight and flag the bias row.
  always_comb begin
    act_s      = buf_r[idx_d_r[IDX_W-1:0]];
    bias_sel_s = (idx_d_r == 7'(BIAS_ADDR));
  end

  l5_mac #(
    .BIAS_SHIFT (BIAS_SHIFT)
  ) u_mac (
    .clk        (clk),
    .rst        (rst),
    .clr        (accept_s),
    .en         (valid_d_r),
    .bias_sel   (bias_sel_s),
    .activation (act_s),
    .weight_row (wt_data),
    .acc        (acc_s)
  );

  // Argmax step counter, only advances inside ARGMAX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arg_i_r <= 4'd0;
    end else if (state_r == ARGMAX) begin
      arg_i_r <= arg_i_r + 4'd1;
    end else begin
      arg_i_r <= 4'd0;
    end
  end

  // Running best; strict compare keeps the lower index on ties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      class_id_r <= 4'd0;
      score_r    <= '0;
    end else if (state_r == ARGMAX) begin
      if (arg_i_r == 4'd0) begin
        class_id_r <= 4'd0;
        score_r    <= acc_s[0];
      end else if (acc_s[arg_i_r] > score_r) begin
        class_id_r <= arg_i_r;
        score_r    <= acc_s[arg_i_r];
      end else begin
        class_id_r <= class_id_r;
        score_r    <= score_r;
      end
    end else begin
      class_id_r <= class_id_r;
      score_r    <= score_r;
    end
  end

  // Registered status/handshake outputs derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_done_r   <= 1'b0;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      tx_done_r   <= accept_s;
      busy_r      <= (state_nx != IDLE);
      out_valid_r <= (state_nx == OUT);
    end
  end

  assign tx_done   = tx_done_r;
  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign wt_addr   = cnt_r;
  assign class_id  = class_id_r;
  assign score     = score_r;

endmodule

// File: tb/tb_layer_5.sv
// Directed self-checking bench for layer_5 with a behavioural 1-cycle ROM.
module tb_layer_5;

  logic               clk;
  logic               rst;
  logic               strt;
  logic signed [17:0] din [64];
  logic               tx_done;
  logic [6:0]         wt_addr;
  logic [89:0]        wt_data;
  logic               busy;
  logic               out_valid;
  logic               out_ready;
  logic [3:0]         class_id;
  logic signed [35:0] score;

  logic [89:0]        rom [0:64];
  int                 n_cmp;
  int                 n_err;

  layer_5 dut (
    .clk       (clk),
    .rst       (rst),
    .strt      (strt),
    .din       (din),
    .tx_done   (tx_done),
    .wt_addr   (wt_addr),
    .wt_data   (wt_data),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .class_id  (class_id),
    .score     (score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM, one cycle read latency.
  always @(posedge clk) begin
    if (wt_addr <= 7'd64) wt_data <= rom[wt_addr];
    else                  wt_data <= '0;
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load(input int mode);
    for (int k = 0; k < 65; k++) begin
      for (int j = 0; j < 10; j++) begin
        case (mode)
          0: rom[k][j*9 +: 9] = (k == 64) ? 9'd0 : 9'(j);
          1: begin
            if (k == 64) rom[k][j*9 +: 9] = (j == 0) ? 9'd127 : 9'd0;
            else         rom[k][j*9 +: 9] = (j == 3) ? 9'd1 : 9'h1FF;
          end
          default: rom[k][j*9 +: 9] = (k == 64) ? 9'd5 : 9'd0;
        endcase
      end
    end
    for (int i = 0; i < 64; i++) din[i] = (mode == 1) ? 18'sd2 : 18'sd1;
  endtask

  task automatic wait_accept(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (tx_done) seen = 1'b1;
    end
    chk({tag, "_accept"}, seen, 1);
    chk({tag, "_busy"}, busy, 1);
  endtask

  // Called 1 ns after the acceptance edge.
  task automatic wait_result(input string tag, input int exp_cls, input longint exp_score);
    int lat;
    int extra_tx;
    lat = 0;
    extra_tx = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (tx_done) extra_tx++;
    end
    chk({tag, "_latency"}, lat, 76);
    chk({tag, "_extra_tx"}, extra_tx, 0);
    chk({tag, "_class"}, class_id, exp_cls);
    chk({tag, "_score"}, score, exp_score);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_tx"}, tx_done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_addr"}, wt_addr, 0);
    chk({tag, "_class"}, class_id, 0);
    chk({tag, "_score"}, score, 0);
  endtask

  initial begin
    bit stable;
    bit found;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    strt = 1'b0;
    out_ready = 1'b0;
    load(0);
    #23;
    check_zero("por");
    @(negedge clk); rst = 1'b0;

    // Ramp, result held under backpressure, then async reset.
    @(negedge clk); strt = 1'b1;
    wait_accept("ramp");
    strt = 1'b0;
    wait_result("ramp", 9, 576);
    #2 rst = 1'b1;
    #1 check_zero("rst_async");
    @(negedge clk); rst = 1'b0; out_ready = 1'b1;

    // Signed weights with bias.
    load(1);
    @(negedge clk); strt = 1'b1;
    wait_accept("sgn");
    strt = 1'b0;
    wait_result("sgn", 3, 128);
    wait_idle("sgn");

    // All-equal scores: lowest index wins.
    load(2);
    @(negedge clk); strt = 1'b1;
    wait_accept("tie");
    strt = 1'b0;
    wait_result("tie", 0, 5);
    wait_idle("tie");

    // Backpressure with strt held, then back-to-back reaccept.
    out_ready = 1'b0;
    @(negedge clk); strt = 1'b1;
    wait_accept("bp");
    wait_result("bp", 0, 5);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!out_valid || tx_done || class_id != 4'd0 || score != 36'sd5) stable = 1'b0;
    end
    chk("bp_stable", stable, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_drop_valid", out_valid, 0);
    chk("bp_drop_tx", tx_done, 0);
    @(posedge clk); #1;
    chk("bp_reaccept_tx", tx_done, 1);
    strt = 1'b0;
    wait_result("bp2", 0, 5);
    wait_idle("bp2");

    // Reset in the middle of MAC, then rerun the ramp frame.
    load(0);
    @(negedge clk); strt = 1'b1;
    wait_accept("mid");
    strt = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (wt_addr == 7'd30) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("mid_addr30", found, 1);
    #2 rst = 1'b1;
    #1 check_zero("mid_rst");
    @(negedge clk); rst = 1'b0;
    @(negedge clk); strt = 1'b1;
    wait_accept("rerun");
    strt = 1'b0;
    wait_result("rerun", 9, 576);
    wait_idle("rerun");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
